// File: rtl/keypad_pkg.sv
// Shared types and helpers for the 4x4 keypad scanner.
// Used by keypad_col_sync and keypad_scan_debounce.
package keypad_pkg;

    localparam int KP_ROWS = 4;
    localparam int KP_COLS = 4;

    typedef enum logic [1:0] {
        SCAN,
        DEBOUNCE,
        PRESSED
    } kp_state_t;

    typedef struct packed {
        logic       valid;
        logic [1:0] col;
    } kp_hit_t;

    // Exactly one low column is a key; none or several (ghost) is idle.
    function automatic kp_hit_t kp_col_hit(
        input logic [KP_COLS-1:0] cols_n
    );
        kp_hit_t h;
        h = '0;
        unique case (cols_n)
            4'b1110: h = '{valid: 1'b1, col: 2'd0};
            4'b1101: h = '{valid: 1'b1, col: 2'd1};
            4'b1011: h = '{valid: 1'b1, col: 2'd2};
            4'b0111: h = '{valid: 1'b1, col: 2'd3};
            default: h = '0;
        endcase
        return h;
    endfunction

    // Printed legend of each key position, for the SSD digit path.
    function automatic logic [3:0] kp_legend(
        input logic [3:0] code
    );
        logic [3:0] l;
        l = 4'h0;
        unique case (code)
            4'd0:    l = 4'h1;
            4'd1:    l = 4'h2;
            4'd2:    l = 4'h3;
            4'd3:    l = 4'hA;
            4'd4:    l = 4'h4;
            4'd5:    l = 4'h5;
            4'd6:    l = 4'h6;
            4'd7:    l = 4'hB;
            4'd8:    l = 4'h7;
            4'd9:    l = 4'h8;
            4'd10:   l = 4'h9;
            4'd11:   l = 4'hC;
            4'd12:   l = 4'hE;
            4'd13:   l = 4'h0;
            4'd14:   l = 4'hF;
            default: l = 4'hD;
        endcase
        return l;
    endfunction

endpackage

// File: rtl/keypad_col_sync.sv
// Two-flop synchronizer for the active-low keypad columns.
// Resets to all-released so no phantom key appears after rst.
module keypad_col_sync
    import keypad_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [KP_COLS-1:0] col_n_i,
    output logic [KP_COLS-1:0] col_n_o
);

    logic [KP_COLS-1:0] meta_q;
    logic [KP_COLS-1:0] sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= '1;
            sync_q <= '1;
        end else begin
            meta_q <= col_n_i;
            sync_q <= meta_q;
        end
    end

    assign col_n_o = sync_q;

endmodule

// File: rtl/keypad_scan_debounce.sv
// 4x4 keypad row scanner with tick-based press/release debounce.
// Optional auto-repeat while held: define KEY_REPEAT_EN.
module keypad_scan_debounce
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE_TICKS     = 2,
    parameter int REPEAT_DELAY_TICKS = 13,
    parameter int REPEAT_RATE_TICKS  = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                tick,
    input  logic [KP_COLS-1:0]  col_n,
    output logic [KP_ROWS-1:0]  row_n,
    output logic [3:0]          key_code,
    output logic                key_valid,
    output logic                key_held
);

    localparam int MAXP_A =
        (DEBOUNCE_TICKS > REPEAT_DELAY_TICKS) ?
        DEBOUNCE_TICKS : REPEAT_DELAY_TICKS;
    localparam int MAXP =
        (MAXP_A > REPEAT_RATE_TICKS) ?
        MAXP_A : REPEAT_RATE_TICKS;
    localparam int CW = $clog2(MAXP + 1);

    localparam logic [CW-1:0] DB_C  = CW'(DEBOUNCE_TICKS);
    localparam logic [CW-1:0] ONE_C = CW'(1);

    logic [KP_COLS-1:0] col_s;
    kp_hit_t            hit;
    logic [3:0]         samp_code;
    logic               all_up;

    kp_state_t          state_q, state_d;
    logic [1:0]         row_idx_q, row_idx_d;
    logic [KP_ROWS-1:0] row_n_q, row_n_d;
    logic [3:0]         cand_q, cand_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [CW-1:0]      cnt_inc;
    logic [3:0]         code_q, code_d;
    logic               valid_q, valid_d;
    logic               held_q, held_d;
    logic               accept;

`ifdef KEY_REPEAT_EN
    localparam logic [CW-1:0] RD_C = CW'(REPEAT_DELAY_TICKS);
    localparam logic [CW-1:0] RR_C = CW'(REPEAT_RATE_TICKS);

    logic [CW-1:0] rep_q, rep_d;
    logic [CW-1:0] rep_inc;
    logic          rep_arm_q, rep_arm_d;

    assign rep_inc = (rep_q == '1) ? rep_q : rep_q + ONE_C;
`endif

    keypad_col_sync u_sync (
        .clk     (clk),
        .rst     (rst),
        .col_n_i (col_n),
        .col_n_o (col_s)
    );

    assign hit       = kp_col_hit(col_s);
    assign samp_code = {row_idx_q, hit.col};
    assign all_up    = (col_s == '1);
    assign cnt_inc   = (cnt_q == '1) ? cnt_q : cnt_q + ONE_C;

    always_comb begin
        state_d   = state_q;
        row_idx_d = row_idx_q;
        cand_d    = cand_q;
        cnt_d     = cnt_q;
        code_d    = code_q;
        valid_d   = 1'b0;
        held_d    = held_q;
        accept    = 1'b0;
`ifdef KEY_REPEAT_EN
        rep_d     = rep_q;
        rep_arm_d = rep_arm_q;
`endif
        if (tick) begin
            unique case (state_q)
                SCAN: begin
                    if (hit.valid) begin
                        cand_d  = samp_code;
                        cnt_d   = ONE_C;
                        state_d = DEBOUNCE;
                        accept  = (ONE_C >= DB_C);
                    end else begin
                        row_idx_d = row_idx_q + 2'd1;
                    end
                end
                DEBOUNCE: begin
                    if (hit.valid && samp_code == cand_q) begin
                        cnt_d  = cnt_inc;
                        accept = (cnt_inc >= DB_C);
                    end else begin
                        state_d   = SCAN;
                        cnt_d     = '0;
                        row_idx_d = row_idx_q + 2'd1;
                    end
                end
                PRESSED: begin
                    if (all_up) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc >= DB_C) begin
                            held_d    = 1'b0;
                            cnt_d     = '0;
                            state_d   = SCAN;
                            row_idx_d = row_idx_q + 2'd1;
                        end
                    end else begin
                        cnt_d = '0;
`ifdef KEY_REPEAT_EN
                        rep_d = rep_inc;
                        if ((!rep_arm_q && rep_inc >= RD_C) ||
                            (rep_arm_q && rep_inc >= RR_C)) begin
                            valid_d   = 1'b1;
                            rep_d     = '0;
                            rep_arm_d = 1'b1;
                        end
`endif
                    end
                end
                default: begin
                    state_d = SCAN;
                    cnt_d   = '0;
                end
            endcase
        end
        // Entering PRESSED reuses cnt as the release counter.
        if (accept) begin
            state_d = PRESSED;
            code_d  = samp_code;
            valid_d = 1'b1;
            held_d  = 1'b1;
            cnt_d   = '0;
`ifdef KEY_REPEAT_EN
            rep_d     = '0;
            rep_arm_d = 1'b0;
`endif
        end
        row_n_d = ~(4'b0001 << row_idx_d);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= SCAN;
            row_idx_q <= 2'd0;
            row_n_q   <= 4'b1110;
            cand_q    <= 4'h0;
            cnt_q     <= '0;
            code_q    <= 4'h0;
            valid_q   <= 1'b0;
            held_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            row_idx_q <= row_idx_d;
            row_n_q   <= row_n_d;
            cand_q    <= cand_d;
            cnt_q     <= cnt_d;
            code_q    <= code_d;
            valid_q   <= valid_d;
            held_q    <= held_d;
        end
    end

`ifdef KEY_REPEAT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rep_q     <= '0;
            rep_arm_q <= 1'b0;
        end else begin
            rep_q     <= rep_d;
            rep_arm_q <= rep_arm_d;
        end
    end
`endif

    assign row_n     = row_n_q;
    assign key_code  = code_q;
    assign key_valid = valid_q;
    assign key_held  = held_q;

endmodule

// File: tb/tb_keypad_scan_debounce.sv
// Directed bench for keypad_scan_debounce: scan, press, bounce,
// ghost, hold/repeat and reset-mid-debounce scenarios.
module tb_keypad_scan_debounce;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick = 1'b0;
    logic [3:0] col_n;
    logic [3:0] row_n;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;

    int n_checks = 0;
    int n_errors = 0;
    int vcount = 0;
    int v0 = 0;

    // 0: no key, 1: single key at krow/kcol, 2: ghost on row 0
    int         kmode = 0;
    logic [1:0] krow = 2'd0;
    logic [1:0] kcol = 2'd0;

    keypad_scan_debounce #(
        .DEBOUNCE_TICKS     (2),
        .REPEAT_DELAY_TICKS (13),
        .REPEAT_RATE_TICKS  (5)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .tick      (tick),
        .col_n     (col_n),
        .row_n     (row_n),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_held  (key_held)
    );

    always #5 clk = ~clk;

    // Switch matrix: a pressed key pulls its column low when its row is driven.
    always_comb begin
        col_n = 4'hF;
        if (kmode == 1 && row_n[krow] == 1'b0)
            col_n[kcol] = 1'b0;
        else if (kmode == 2 && row_n[0] == 1'b0)
            col_n = 4'b1100;
    end

    initial begin
        forever begin
            repeat (9) @(negedge clk);
            tick = 1'b1;
            @(negedge clk);
            tick = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (key_valid === 1'b1)
            vcount++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: sim time exceeded");
        $fatal(1, "watchdog");
    end

    task automatic check(
        input string      tag,
        input logic [7:0] got,
        input logic [7:0] exp
    );
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h",
                     tag, got, exp);
        end
    endtask

    task automatic next_tick();
        int n;
        n = 0;
        do begin
            @(posedge clk);
            n++;
        end while (!tick && n < 25);
        if (!tick)
            check("tick_timeout", 8'd0, 8'd1);
        @(negedge clk);
    endtask

    task automatic wait_row(input logic [3:0] r);
        for (int i = 0; i < 8 && row_n !== r; i++)
            next_tick();
        check("wait_row", 8'(row_n), 8'(r));
    endtask

    logic [3:0] scan_seq [5];
    logic [3:0] ghost_seq [4];

    initial begin
        scan_seq  = '{4'b1101, 4'b1011, 4'b0111,
                      4'b1110, 4'b1101};
        ghost_seq = '{4'b1101, 4'b1011, 4'b0111,
                      4'b1110};

        repeat (3) @(negedge clk);
        check("rst_row", 8'(row_n), 8'h0E);
        check("rst_code", 8'(key_code), 8'h00);
        check("rst_valid", 8'(key_valid), 8'h00);
        check("rst_held", 8'(key_held), 8'h00);
        rst = 1'b0;

        // idle scan rotation
        v0 = vcount;
        for (int i = 0; i < 5; i++) begin
            next_tick();
            check("scan_row", 8'(row_n), 8'(scan_seq[i]));
        end
        check("scan_no_valid", 8'(vcount - v0), 8'd0);

        // asynchronous reset between edges
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("arst_row", 8'(row_n), 8'h0E);
        check("arst_code", 8'(key_code), 8'h00);
        check("arst_valid", 8'(key_valid), 8'h00);
        check("arst_held", 8'(key_held), 8'h00);
        @(negedge clk);
        rst = 1'b0;

        // hold key 0 for 25 ticks, starting while row 3 is driven
        krow = 2'd0;
        kcol = 2'd0;
        wait_row(4'b0111);
        v0 = vcount;
        kmode = 1;
        repeat (25) next_tick();
        check("rep_held", 8'(key_held), 8'd1);
        kmode = 0;
        repeat (3) next_tick();
`ifdef KEY_REPEAT_EN
        check("rep_count", 8'(vcount - v0), 8'd3);
`else
        check("rep_count", 8'(vcount - v0), 8'd1);
`endif
        check("rep_code", 8'(key_code), 8'h00);
        check("rep_released", 8'(key_held), 8'd0);

        // clean press of row 2 col 1
        krow = 2'd2;
        kcol = 2'd1;
        wait_row(4'b1011);
        v0 = vcount;
        kmode = 1;
        next_tick();
        check("press_t1_valid", 8'(key_valid), 8'd0);
        next_tick();
        check("press_valid", 8'(key_valid), 8'd1);
        check("press_code", 8'(key_code), 8'h09);
        check("press_held", 8'(key_held), 8'd1);
        @(negedge clk);
        check("press_pulse_w", 8'(key_valid), 8'd0);
        kmode = 0;
        next_tick();
        check("release_t1_held", 8'(key_held), 8'd1);
        next_tick();
        check("release_held", 8'(key_held), 8'd0);
        check("release_row", 8'(row_n), 8'h07);
        check("press_count", 8'(vcount - v0), 8'd1);

        // bounce: key seen on one tick only
        wait_row(4'b1011);
        v0 = vcount;
        kmode = 1;
        next_tick();
        kmode = 0;
        next_tick();
        check("bounce_row", 8'(row_n), 8'h07);
        check("bounce_count", 8'(vcount - v0), 8'd0);
        check("bounce_held", 8'(key_held), 8'd0);

        // ghost: two columns low on row 0
        wait_row(4'b1110);
        v0 = vcount;
        kmode = 2;
        for (int i = 0; i < 4; i++) begin
            next_tick();
            check("ghost_row", 8'(row_n), 8'(ghost_seq[i]));
        end
        kmode = 0;
        check("ghost_count", 8'(vcount - v0), 8'd0);

        // reset while debouncing a press
        krow = 2'd2;
        kcol = 2'd1;
        wait_row(4'b1011);
        v0 = vcount;
        kmode = 1;
        next_tick();
        check("mid_pre_code", 8'(key_code), 8'h09);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_row", 8'(row_n), 8'h0E);
        check("mid_rst_code", 8'(key_code), 8'h00);
        check("mid_rst_valid", 8'(key_valid), 8'h00);
        check("mid_rst_held", 8'(key_held), 8'h00);
        kmode = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (4) next_tick();
        check("mid_rst_count", 8'(vcount - v0), 8'd0);
        check("mid_rst_rows", 8'(row_n), 8'h0E);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
